// File: rtl/multiplexer.sv
// Registered 4:1 direction multiplexer with one-hot route report and output valid.
// Optional MULTIPLEXER_SYNC_INPUTS_EN adds 2-flop input synchronizers (latency 3).
module multiplexer #(
    parameter logic RESET_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       select0,
    input  logic       select1,
    input  logic       up,
    input  logic       right,
    input  logic       down,
    input  logic       left,
    output logic       out,
    output logic [3:0] sel_onehot,
    output logic       out_valid
);

    function automatic logic [3:0] onehot_of(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    function automatic logic route(input logic [1:0] sel, input logic [3:0] dir);
        return dir[sel];
    endfunction

    logic [1:0] mux_sel;
    logic [3:0] mux_dir;
    logic       mux_vld;

`ifdef MULTIPLEXER_SYNC_INPUTS_EN
    // Select and data are synchronized as one bundle so every sample reaching
    // the mux register carries a select and data taken at the same edge.
    logic [5:0] sync_p0;
    logic [5:0] sync_p1;
    logic       vld_p0;
    logic       vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            sync_p0 <= {select1, select0, left, down, right, up};
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
        end
    end

    assign mux_sel = sync_p1[5:4];
    assign mux_dir = sync_p1[3:0];
    assign mux_vld = vld_p1;
`else
    assign mux_sel = {select1, select0};
    assign mux_dir = {left, down, right, up};
    assign mux_vld = 1'b1;
`endif

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= RESET_OUT;
            sel_onehot <= 4'b0000;
            out_valid  <= 1'b0;
        end else begin
            out        <= route(mux_sel, mux_dir);
            sel_onehot <= onehot_of(mux_sel);
            out_valid  <= mux_vld;
        end
    end

endmodule

// File: tb/tb_multiplexer.sv
// Self-checking bench for multiplexer: directed cases plus random stimulus
// against a sample-history reference model.
module tb_multiplexer;

`ifdef MULTIPLEXER_SYNC_INPUTS_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic       select0, select1;
    logic       up, right, down, left;
    logic       out;
    logic [3:0] sel_onehot;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic       up, right, down, left;
    } sample_t;

    sample_t hist[$];
    int      since_rst = 0;

    multiplexer #(.RESET_OUT(1'b0)) dut (
        .clk(clk), .rst(rst), .select0(select0), .select1(select1),
        .up(up), .right(right), .down(down), .left(left),
        .out(out), .sel_onehot(sel_onehot), .out_valid(out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: record what the DUT samples, then compare all outputs to the model.
    task automatic step();
        sample_t s;
        sample_t e;
        logic    exp_valid;
        logic    exp_out;
        logic [3:0] exp_oh;
        @(posedge clk);
        s.rst = rst; s.sel = {select1, select0};
        s.up = up; s.right = right; s.down = down; s.left = left;
        hist.push_front(s);
        if (hist.size() > 8) void'(hist.pop_back());
        if (rst) since_rst = 0;
        else since_rst++;
        exp_valid = !rst && (since_rst >= LAT);
        #1;
        check("out_valid", out_valid, exp_valid);
        if (rst) begin
            check("rst_out", out, 1'b0);
            check("rst_onehot", sel_onehot, 4'b0000);
        end else if (exp_valid) begin
            e = hist[LAT-1];
            case (e.sel)
                2'd0: begin exp_out = e.up;    exp_oh = 4'b0001; end
                2'd1: begin exp_out = e.right; exp_oh = 4'b0010; end
                2'd2: begin exp_out = e.down;  exp_oh = 4'b0100; end
                default: begin exp_out = e.left; exp_oh = 4'b1000; end
            endcase
            check("out", out, exp_out);
            check("onehot", sel_onehot, exp_oh);
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply(input logic [1:0] sel, input logic u, input logic r,
                         input logic d, input logic l);
        {select1, select0} = sel;
        up = u; right = r; down = d; left = l;
    endtask

    initial begin
        rst = 1'b1;
        apply(2'b11, 1, 1, 1, 1);
        hold(2);
        check("reset_out", out, 1'b0);
        check("reset_onehot", sel_onehot, 4'b0000);
        check("reset_valid", out_valid, 1'b0);

        rst = 1'b0;
        apply(2'b00, 0, 0, 0, 0);
        hold(LAT);
        check("up0_out", out, 1'b0);
        check("up0_onehot", sel_onehot, 4'b0001);
        check("up0_valid", out_valid, 1'b1);
        apply(2'b00, 1, 0, 0, 0);
        hold(LAT);
        check("up1_out", out, 1'b1);

        apply(2'b01, 0, 1, 0, 0);
        hold(LAT);
        check("right_out", out, 1'b1);
        check("right_onehot", sel_onehot, 4'b0010);
        apply(2'b10, 0, 0, 1, 0);
        hold(LAT);
        check("down_out", out, 1'b1);
        check("down_onehot", sel_onehot, 4'b0100);
        apply(2'b11, 0, 0, 0, 1);
        hold(LAT);
        check("left_out", out, 1'b1);
        check("left_onehot", sel_onehot, 4'b1000);

        apply(2'b11, 1, 1, 1, 0);
        hold(LAT);
        check("unsel_ignored", out, 1'b0);

        apply(2'b00, 0, 0, 0, 0);
        hold(LAT);
        apply(2'b11, 0, 0, 0, 1);
        hold(LAT);
        check("sim_change_out", out, 1'b1);
        check("sim_change_onehot", sel_onehot, 4'b1000);

        rst = 1'b1;
        hold(1);
        check("pulse_out", out, 1'b0);
        check("pulse_valid", out_valid, 1'b0);
        rst = 1'b0;
        if (LAT > 1) begin
            hold(LAT - 1);
            check("recover_not_yet", out_valid, 1'b0);
            hold(1);
        end else begin
            hold(1);
        end
        check("recover_valid", out_valid, 1'b1);
        check("recover_out", out, 1'b1);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            apply(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
